// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flush bubbles and
// memory-wait freezes, with a saturating count of PC-stalled cycles.
module hazard_ctrl #(
    parameter int BR_BUBBLES = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             branch_taken,
    input  logic             mem_busy,
    input  logic             cnt_clr,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [1:0]       o_dbg_state
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    localparam logic [2:0] BCNT_RELOAD = 3'(BR_BUBBLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_pend_flush;
    logic             w_pend_nxt;
    logic [2:0]       r_bcnt;
    logic [2:0]       w_bcnt_nxt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_load_use;
    logic w_branch;
    logic w_in_flush;
    logic w_pc_en;
    logic w_ifid_en;
    logic w_ifid_flush;
    logic w_idex_flush;

    assign w_load_use = ex_memread && (ex_rt != 5'd0) &&
                        ((id_uses_rs && (id_rs == ex_rt)) ||
                         (id_uses_rt && (id_rt == ex_rt)));

    // A branch that arrived while memory was busy is replayed on MEMWAIT exit.
    assign w_branch   = branch_taken || ((r_state == MEMWAIT) && r_pend_flush);

    // Non-zero bcnt in MEMWAIT means a bubble sequence was interrupted.
    assign w_in_flush = (r_state == FLUSH) ||
                        ((r_state == MEMWAIT) && (r_bcnt != 3'd0));

    always_comb begin
        w_pc_en      = 1'b1;
        w_ifid_en    = 1'b1;
        w_ifid_flush = 1'b0;
        w_idex_flush = 1'b0;
        w_state_nxt  = r_state;
        w_pend_nxt   = r_pend_flush;
        w_bcnt_nxt   = r_bcnt;

        if (mem_busy) begin
            w_pc_en     = 1'b0;
            w_ifid_en   = 1'b0;
            w_state_nxt = MEMWAIT;
            if (branch_taken) begin
                w_pend_nxt = 1'b1;
            end
        end else if (w_branch) begin
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
            w_pend_nxt   = 1'b0;
            if (BR_BUBBLES > 1) begin
                w_bcnt_nxt  = BCNT_RELOAD;
                w_state_nxt = FLUSH;
            end else begin
                w_bcnt_nxt  = 3'd0;
                w_state_nxt = RUN;
            end
        end else if (w_in_flush) begin
            w_ifid_flush = 1'b1;
            if (r_bcnt <= 3'd1) begin
                w_bcnt_nxt  = 3'd0;
                w_state_nxt = RUN;
            end else begin
                w_bcnt_nxt  = r_bcnt - 3'd1;
                w_state_nxt = FLUSH;
            end
        end else if (w_load_use) begin
            w_pc_en      = 1'b0;
            w_ifid_en    = 1'b0;
            w_idex_flush = 1'b1;
            w_state_nxt  = RUN;
        end else begin
            w_state_nxt = RUN;
        end

        // While held in reset the pipeline is kept frozen and filled with NOPs.
        if (!rst) begin
            w_pc_en      = 1'b0;
            w_ifid_en    = 1'b0;
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= RUN;
            r_pend_flush <= 1'b0;
            r_bcnt       <= 3'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_pend_flush <= w_pend_nxt;
            r_bcnt       <= w_bcnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (cnt_clr) begin
            r_stall_cnt <= '0;
        end else if (!w_pc_en && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign pc_en       = w_pc_en;
    assign ifid_en     = w_ifid_en;
    assign ifid_flush  = w_ifid_flush;
    assign idex_flush  = w_idex_flush;
    assign stall_cnt   = r_stall_cnt;
    assign o_dbg_state = r_state;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter BR_BUBBLES, default 1, meaning total flush cycles after a taken branch (legal range 1..7).
REQ-002 Parameter CNT_W, default 16, meaning width of the stall performance counter.
REQ-003 Port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-004 Port rst, input, 1, reset; asynchronous and active-low.
REQ-005 Port id_rs, id_rt, input, 5 each, source register numbers of the instruction in ID.
REQ-006 Port id_uses_rs, id_uses_rt, input, 1 each, high when the ID instruction reads the corresponding source register.
REQ-007 Port ex_memread, input, 1, high when the EX instruction is a load.
REQ-008 Port ex_rt, input, 5, destination register of the EX load.
REQ-009 Port branch_taken, input, 1, single-cycle pulse from EX: branch/jump resolved taken.
REQ-010 Port mem_busy, input, 1, high while instruction or data memory cannot complete this cycle.
REQ-011 Port cnt_clr, input, 1, synchronous clear of stall_cnt.
REQ-012 Port pc_en, output, 1, PC write enable.
REQ-013 Port ifid_en, output, 1, IF/ID pipeline register enable.
REQ-014 Port ifid_flush, output, 1, loads zero (NOP) into IF/ID; overrides ifid_en.
REQ-015 Port idex_flush, output, 1, inserts a bubble into ID/EX.
REQ-016 Port stall_cnt, output, CNT_W, count of cycles with pc_en=0.

Function
REQ-017 The block SHALL compute load_use = ex_memread & (ex_rt!=0) & ((id_uses_rs & id_rs==ex_rt) | (id_uses_rt & id_rt==ex_rt)).
REQ-018 The FSM SHALL have states RUN, MEMWAIT and FLUSH, plus a 1-bit pend_flush flag and a 3-bit bubble counter bcnt.
REQ-019 Outputs SHALL be combinational from state and inputs; event priority SHALL be mem_busy > branch/pend_flush > load_use.
REQ-020 In any state with mem_busy=1: pc_en=0, ifid_en=0, ifid_flush=0, idex_flush=0; next state MEMWAIT; branch_taken=1 in that cycle sets pend_flush.
REQ-021 In MEMWAIT with mem_busy=0: with pend_flush=1, behave as a taken branch (REQ-022) and clear pend_flush; otherwise, behave as RUN.
REQ-022 Taken branch (RUN or MEMWAIT exit, mem_busy=0): pc_en=1, ifid_flush=1, idex_flush=1; if BR_BUBBLES>1, load bcnt=BR_BUBBLES-1 and go FLUSH, else go RUN.
REQ-023 In FLUSH with mem_busy=0: pc_en=1, ifid_flush=1, idex_flush=0; decrement bcnt; go RUN when bcnt reaches 1 this cycle.
REQ-024 A branch_taken arriving in FLUSH SHALL restart the bubble sequence (reload bcnt, assert idex_flush).
REQ-025 A FLUSH interrupted by mem_busy SHALL resume with bcnt preserved after MEMWAIT.
REQ-026 In RUN with load_use=1 and no higher-priority event: pc_en=0, ifid_en=0, idex_flush=1, ifid_flush=0; state remains RUN.
REQ-027 Otherwise: pc_en=1, ifid_en=1, both flushes 0.
REQ-028 stall_cnt SHALL increment each cycle pc_en=0, saturate at all-ones, and cnt_clr SHALL take precedence (value 0 next cycle).

Reset
REQ-029 With rst low: state=RUN, pend_flush=0, bcnt=0, stall_cnt=0 immediately (asynchronous); outputs pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1.
REQ-030 Release of rst SHALL give pc_en=1, ifid_en=1, flushes 0 in the first cycle, provided inputs are idle; reset asserted mid-FLUSH or mid-MEMWAIT SHALL discard the pending work.

Verification
REQ-031 ex_memread=1, ex_rt=5, id_rs=5, id_uses_rs=1 for one cycle -> pc_en=0, ifid_en=0, idex_flush=1 that cycle; stall_cnt +1.
REQ-032 Same as REQ-031 but ex_rt=0 -> no stall; pc_en=1, idex_flush=0.
REQ-033 BR_BUBBLES=3, branch_taken pulse -> ifid_flush=1 for 3 consecutive cycles, idex_flush=1 only in the first cycle, then RUN.
REQ-034 mem_busy high 4 cycles with branch_taken in cycle 2 -> 4 cycles with pc_en=0 and no flush; flush in cycle 5; stall_cnt=4.
REQ-035 Load-use and branch_taken in the same cycle -> branch wins: pc_en=1, ifid_flush=1, idex_flush=1.
REQ-036 Hold pc_en=0 for 2^CNT_W+2 cycles with CNT_W=4 -> stall_cnt saturates at 15; cnt_clr -> 0; rst low mid-FLUSH -> outputs per REQ-029 at once.
